// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one word-addressed memory between a
// read-only fetch port (0) and a read/write data port (1), rejecting misaligned addresses.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   output logic          done0,
   output logic          err0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          done1,
   output logic          err1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] memAddr,
   output logic [DW-1:0] memIn,
   output logic          memRead,
   output logic          memWrite,
   input  logic [DW-1:0] memOut
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_n;
   logic last_grant, gnt, we_q, err_q;
   logic any, sel, mis, grant;
   logic [AW-1:0] sel_addr;
   always_comb begin
      any      = req0 | req1;
      sel      = (req0 & req1) ? ~last_grant : req1;
      sel_addr = sel ? addr1 : addr0;
      mis      = sel_addr[1:0] != 2'b00;
      grant    = (state == IDLE) & any;
      state_n  = (state == IDLE)   ? (any ? (mis ? RESP : ACCESS) : IDLE) :
                 (state == ACCESS) ? RESP : IDLE;
      // strobes decode straight from state so an async reset kills an in-flight write
      memRead  = (state == ACCESS) & ~we_q;
      memWrite = (state == ACCESS) & we_q;
      done0    = (state == RESP) & ~gnt;
      done1    = (state == RESP) & gnt;
      err0     = done0 & err_q;
      err1     = done1 & err_q;
      busy     = state != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         memAddr    <= '0;
         memIn      <= '0;
         rdata      <= '0;
      end else begin
         state <= state_n;
         if (grant) begin
            last_grant <= sel;
            gnt        <= sel;
            we_q       <= sel & we1;
            err_q      <= mis;
            // misaligned grants never reach memory, so its address/data lines keep their old values
            if (!mis) memAddr <= sel_addr;
            if (!mis && sel) memIn <= wdata1;
         end
         if (memRead) rdata <= memOut;
      end
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single word-addressed `mem` instance between an instruction-fetch requester (port 0, read-only) and a data requester (port 1, read/write). It grants one requester at a time, sequences the memory strobes, captures read data into a register, and rejects misaligned addresses without touching memory. It sits between the CPU front/back ends and `mem`, whose `memOut` is combinational on `address`/`read` and whose write commits on the rising `clk` edge.

## Interface
- `AW`, 32, address width (byte address; word-aligned when `addr[1:0]==0`)
- `DW`, 32, data width

- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`  in  1  port 0 read request
- `addr0`  in  AW  port 0 byte address
- `done0`  out  1  port 0 transaction complete (1-cycle pulse)
- `err0`  out  1  port 0 misaligned-address error, valid with `done0`
- `req1`  in  1  port 1 request
- `we1`  in  1  port 1: 1 = write, 0 = read
- `addr1`  in  AW  port 1 byte address
- `wdata1`  in  DW  port 1 write data
- `done1`  out  1  port 1 transaction complete (1-cycle pulse)
- `err1`  out  1  port 1 misaligned-address error, valid with `done1`
- `rdata`  out  DW  registered read data, shared by both ports
- `busy`  out  1  high in any state other than IDLE
- `memAddr`  out  AW  to `mem` address
- `memIn`  out  DW  to `mem` write data
- `memRead`  out  1  to `mem` read strobe
- `memWrite`  out  1  to `mem` write strobe
- `memOut`  in  DW  from `mem` read data

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- Reset values: `memAddr`=0, `memIn`=0, `memRead`=0, `memWrite`=0, `rdata`=0, `done0/1`=0, `err0/1`=0, `busy`=0, `lastGrant`=1 (port 0 wins first tie).
- IDLE: sample `req0`/`req1`. None -> stay. One -> grant it. Both -> grant the port that is not `lastGrant` (round-robin). On grant: update `lastGrant`, latch address, `we` (0 for port 0), write data.
- Grant with aligned address -> ACCESS. Misaligned (`addr[1:0]!=0`) -> RESP with err flag set; no memory strobe is ever asserted.
- ACCESS (one cycle): `memAddr`/`memIn` from latched values; `memRead`=~we, `memWrite`=we. At the closing edge: read -> `rdata`<=`memOut`; write commits in `mem`. -> RESP.
- RESP (one cycle): `done` of granted port =1; `err` =1 only if misaligned. `rdata` unchanged by writes and errors. -> IDLE.
- `memRead`/`memWrite` are high only in ACCESS, never both. `memAddr`/`memIn` hold their last values outside ACCESS.
- Requesters hold `req`, address, `we`, and data stable until their `done`, and must drop `req` in the cycle after `done` unless issuing a new request. `req` is sampled only in IDLE, so changes during ACCESS/RESP are ignored.

## Timing
- Aligned access: `req` high before edge E0 -> ACCESS during E0–E1 -> `done` and valid `rdata` during E1–E2. Throughput is one transaction per 3 cycles.
- Misaligned access: `done`+`err` during E0–E1. No ACCESS cycle.
- Both ports requesting continuously: grants strictly alternate.
- `rst` asserted in any state: outputs go to reset values immediately (asynchronously). `memWrite` drops before the next edge, so an in-flight write is aborted and memory is unchanged. The pending transaction is lost, no `done`. After `rst` falls: IDLE, `lastGrant`=1.

## Test plan
- Port 1 writes 0x12345678 to 16, then 0x89abcdef to 24 -> `done1` pulse each, 3 cycles apart. `memWrite` high exactly one cycle each; `memRead` never high.
- Port 0 reads 16, 20, 24 after the writes -> `rdata`=0x12345678, unchanged/don't-care contents at 20, 0x89abcdef, each valid with `done0`.
- `req0` and `req1` both held high from reset, 4 transactions -> grant order 0,1,0,1. Each `done` belongs to the granted port only.
- Port 1 read at address 18 -> `done1`=`err1`=1 one cycle after the request edge. `memRead`/`memWrite` stay 0. `rdata` keeps its prior value.
- Port 1 write 0xdeadbeef to 16 with `rst` pulsed during ACCESS -> all outputs 0 immediately, no `done1`. A subsequent port 0 read of 16 returns 0x12345678.
- Request pulsed while the arbiter is in ACCESS on another port -> ignored until IDLE. A held request is served next, with `busy` high throughout.
